// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS fetch unit.
// Fetch FSM states and the buffered fetch entry.
package mips_fetch_pkg;

  localparam int WORD_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem response and decode.
// Flush beats push and pop; occ never wraps.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic [OW-1:0] occ,
  output fetch_entry_t head
);

  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic do_pop;
  logic do_push;

  assign do_pop  = pop && (occ != '0) && !flush;
  assign do_push = push && !flush && ((occ != FULL) || do_pop);
  assign head    = mem[rd];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  // Entry storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd  <= '0;
      wr  <= '0;
      occ <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop) rd <= nxt(rd);
      if (do_push && !do_pop) occ <= occ + OW'(1);
      else if (do_pop && !do_push) occ <= occ - OW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and imem sequencer for the MIPS core.
// Issues word fetches, buffers tagged responses, handles redirects.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  localparam int OW = $clog2(DEPTH + 1);

  state_t        state;
  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [OW-1:0] occ;
  logic [OW:0]   used;
  logic          issue;
  logic          kill;
  logic          push;
  logic          pop;
  fetch_entry_t  din;
  fetch_entry_t  head;

  // Issue only from registered counts; redirect suppresses it.
  assign used  = {1'b0, occ} + (OW + 1)'(inflight);
  assign issue = (state == RUN) && !redirect_valid
              && (used < (OW + 1)'(DEPTH));

  // A response landing with a redirect or in HALT is dropped.
  assign kill = redirect_valid || (state == HALT);
  assign push = inflight && !kill;
  assign pop  = if_valid && if_ready;

  assign din.pc    = inflight_pc;
  assign din.instr = imem_rdata;

  assign imem_en   = issue;
  assign imem_addr = pc;
  assign if_valid  = (occ != '0);
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_pc     = if_valid ? head.pc : '0;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (din),
    .pop  (pop),
    .flush(redirect_valid),
    .occ  (occ),
    .head (head)
  );

  // FSM, PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_err   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'(WORD_BYTES);
      end
      unique case (state)
        IDLE:    if (fetch_en) state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= HALT;
      endcase
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) begin
          state     <= HALT;
          fetch_err <= 1'b1;
        end else if (state != HALT) begin
          pc <= redirect_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Memory returns addr/4 one cycle after each fetch strobe.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;

  int checks;
  int failures;
  int n_issue;

  fetch_sequencer #(
    .RESET_PC(32'h0),
    .DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= imem_en ? (imem_addr >> 2) : 32'hDEAD_BEEF;
    if (imem_en === 1'b1) n_issue <= n_issue + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  int base;
  int bad;
  logic [31:0] got_pc [$];

  initial begin
    checks = 0;
    failures = 0;
    n_issue = 0;
    reset = 1'b1;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset state, then back-to-back streaming.
    do_reset();
    chk("rst_en", 32'(imem_en), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_err", 32'(fetch_err), 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("str_en", 32'(imem_en), 1);
      chk("str_addr", imem_addr, 32'(4 * (k - 1)));
      if (k < 3) begin
        chk("str_novalid", 32'(if_valid), 0);
      end else begin
        chk("str_valid", 32'(if_valid), 1);
        chk("str_pc", if_pc, 32'(4 * (k - 3)));
        chk("str_instr", if_instr, 32'(k - 3));
      end
    end

    // Backpressure fills exactly DEPTH, then drains in order.
    do_reset();
    if_ready = 1'b0;
    base = n_issue;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k >= 3) chk("bp_hold_pc", if_pc, 32'h0);
    end
    chk("bp_issued", 32'(n_issue - base), 4);
    chk("bp_en_off", 32'(imem_en), 0);
    if_ready = 1'b1;
    #1;
    for (int k = 0; k <= 5; k++) begin
      chk("bp_valid", 32'(if_valid), 1);
      chk("bp_pc", if_pc, 32'(4 * k));
      chk("bp_instr", if_instr, 32'(k));
      step();
    end

    // Aligned redirect while pc 8 is held.
    do_reset();
    for (int k = 1; k <= 5; k++) step();
    if_ready = 1'b0;
    #1;
    chk("rd_head", if_pc, 32'h8);
    step();
    chk("rd_held", if_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_noissue", 32'(imem_en), 0);
    step();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    #1;
    chk("rd_en", 32'(imem_en), 1);
    chk("rd_addr", imem_addr, 32'h40);
    chk("rd_flushed", 32'(if_valid), 0);
    step();
    chk("rd_gap", 32'(if_valid), 0);
    step();
    chk("rd_t_valid", 32'(if_valid), 1);
    chk("rd_t_pc", if_pc, 32'h40);
    chk("rd_t_instr", if_instr, 32'h10);
    step();
    chk("rd_t1_pc", if_pc, 32'h44);
    chk("rd_t1_instr", if_instr, 32'h11);

    // Misaligned redirect halts until reset.
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("mis_err", 32'(fetch_err), 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (imem_en !== 1'b0 || if_valid !== 1'b0) bad++;
      step();
    end
    chk("mis_quiet", 32'(bad), 0);
    chk("mis_sticky", 32'(fetch_err), 1);
    do_reset();
    chk("mis_clr", 32'(fetch_err), 0);
    chk("mis_rpc", imem_addr, 32'h0);
    step();
    chk("mis_restart", 32'(imem_en), 1);
    chk("mis_raddr", imem_addr, 32'h0);

    // fetch_en drop after three issues, then resume.
    do_reset();
    base = n_issue;
    got_pc.delete();
    for (int k = 1; k <= 14; k++) begin
      step();
      fetch_en = (k < 3);
      #1;
      if (if_valid) got_pc.push_back(if_pc);
    end
    chk("fe_issued", 32'(n_issue - base), 3);
    chk("fe_count", 32'(got_pc.size()), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_pc.size()) chk("fe_pc", got_pc[k], 32'(4 * k));
    end
    fetch_en = 1'b1;
    step();
    chk("fe_resume_en", 32'(imem_en), 1);
    chk("fe_resume_addr", imem_addr, 32'hC);

    // Reset with a full-ish buffer and a fetch in flight.
    do_reset();
    if_ready = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    chk("rr_pre_valid", 32'(if_valid), 1);
    do_reset();
    if_ready = 1'b1;
    chk("rr_valid", 32'(if_valid), 0);
    chk("rr_addr", imem_addr, 32'h0);
    step();
    chk("rr_c1", 32'(if_valid), 0);
    step();
    chk("rr_c2", 32'(if_valid), 0);
    step();
    chk("rr_c3_pc", if_pc, 32'h0);
    chk("rr_c3_instr", if_instr, 32'h0);
    chk("rr_c3_valid", 32'(if_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the instruction memory for the MIPS core. Owns the PC, issues word fetches to Instruction_Mem, tags returned instructions with their PC and buffers them. Presents them to decode over a valid/ready handshake. Applies branch/jump redirects with flush of in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
DEPTH, 4, instruction buffer entries; legal range 2..16. Full throughput needs DEPTH>=3.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
fetch_en  in  1  permits new fetches while 1
imem_en  out  1  fetch strobe: imem_addr is valid this cycle
imem_addr  out  32  byte address to Instruction_Mem
imem_rdata  in  32  instruction, returned one cycle after the imem_en cycle
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  redirect target
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_ready  in  1  decode accepts this cycle
if_instr  out  32  instruction at buffer head
if_pc  out  32  PC of if_instr
fetch_err  out  1  sticky: misaligned redirect target seen

Behaviour:
- Reset, sampled on a clk edge, overrides everything:
  - pc=RESET_PC, state=IDLE, buffer empty, inflight=0.
  - Outputs: imem_en=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.
  - Reset mid-operation discards the buffer and any in-flight response.
- States:
  - IDLE -> RUN when fetch_en=1.
  - RUN -> IDLE when fetch_en=0.
  - Any state -> HALT on redirect_valid with redirect_pc[1:0]!=0.
  - HALT is left only by reset.
- Issue:
  - In RUN, imem_en=1 iff occ+inflight<DEPTH and redirect_valid=0; imem_addr=pc.
  - The issue condition uses registered counts only. There is no combinational path from if_ready or redirect_pc to imem_en/imem_addr.
  - On issue: pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); inflight<=1; inflight_pc<=pc.
- Response:
  - In the cycle after an issue, imem_rdata and inflight_pc are pushed to the buffer unless killed.
  - Latency: imem_en at cycle t -> if_valid with that instruction at cycle t+2.
- Output:
  - if_valid=(occ!=0); if_instr/if_pc come from the head entry.
  - Pop when if_valid & if_ready.
  - Head fields stay stable while if_valid=1 and if_ready=0.
  - Push and pop in the same cycle leave occ unchanged.
- Redirect (redirect_valid=1, target aligned):
  - pc<=redirect_pc; buffer flushed; a response arriving next cycle is dropped (kill flag); no issue this cycle.
  - A handshake completing in the same cycle counts as consumed; everything behind it is discarded.
  - Target fetched at N+1, if_valid for the target at N+3.
  - Redirect while in IDLE only updates pc and flushes.
- Misaligned redirect: fetch_err<=1, state=HALT, buffer flushed, no further issue; if_valid=0 from the next cycle.
- fetch_en=0: no new issue; the in-flight response is still pushed; the buffer continues to drain.
- Full buffer: no issue. Empty buffer with if_ready=1: no effect.
- Counters: occ is $clog2(DEPTH+1) bits and never overflows or underflows; inflight is 1 bit.

Decomposition:
- Package mips_fetch_pkg:
  - state enum {IDLE, RUN, HALT};
  - fetch entry typedef {pc[31:0], instr[31:0]};
  - constants WORD_BYTES=4, RESET_PC_DEFAULT.
- Sub-module fetch_fifo: synchronous FIFO of DEPTH fetch entries with push, pop, flush, occ, head outputs. Flush has priority over push and pop.

Test Plan:
- Reset with fetch_en=1, if_ready=1, memory returning word at addr N = N/4 -> imem_addr 0,4,8,... one per cycle from cycle 1; if_valid from cycle 3 with (pc,instr)=(0,0),(4,1),(8,2) back-to-back; no gaps.
- if_ready=0 for 10 cycles -> exactly DEPTH=4 fetches issued (0..12); if_pc holds 0; release -> 0,4,8,12,16 delivered in order with no loss or duplicate.
- redirect_pc=32'h40 while instr at pc 8 is held -> pc 8, 12 and the in-flight fetch are discarded; imem_addr=32'h40 next cycle; if_pc=32'h40 two cycles later, then 32'h44.
- redirect_pc=32'h42 -> fetch_err=1 next cycle; imem_en stays 0 and if_valid stays 0 for 20 cycles; reset clears fetch_err and restarts at RESET_PC.
- fetch_en dropped after 3 issues -> all 3 instructions delivered; no further imem_en; re-raise -> resumes at pc 12.
- reset asserted with the buffer holding 3 entries plus one in flight -> next cycle if_valid=0, imem_addr=0; the old rdata never appears.
